// File: rtl/aes_key_expand_gen.sv
// Runtime-selectable AES-128/192/256 key schedule: one schedule word per cycle,
// assembled into 128-bit round keys and handed out over a valid/ready handshake.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expand_gen #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [1:0]   ksz,
  input  logic [255:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy,
  output logic         ksz_err
);
  // Handshake: a round key transfers on a rising edge where rk_valid & rk_ready;
  // rk_valid and the payload stay stable until that edge; rk_ready is ignored
  // while rk_valid is low.
  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [255:0]  key_q, key_d;
  logic [31:0]   win_q [8];
  logic [31:0]   win_d [8];
  logic [31:0]   asm_q [3];
  logic [31:0]   asm_d [3];
  logic [5:0]    cnt_q, cnt_d;
  logic [2:0]    ph_q, ph_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [1:0]    mode_q, mode_d;
  logic          rk_valid_q, rk_valid_d;
  logic [31:0]   wo0_q, wo0_d, wo1_q, wo1_d, wo2_q, wo2_d, wo3_q, wo3_d;
  logic [3:0]    rk_idx_q, rk_idx_d;
  logic          rk_last_q, rk_last_d;
  logic          ksz_err_q, ksz_err_d;

  logic [5:0]    nk, total;
  logic [2:0]    nk_m1;
  logic [31:0]   old_word, prev_word, sbox_in, sub_word, temp_word, new_word;
  logic          ksz_ok, accept, word_fire, fourth;

  always_comb begin
    case (mode_q)
      2'd1:    begin nk = 6'd6; nk_m1 = 3'd5; total = 6'd52; old_word = win_q[5]; end
      2'd2:    begin nk = 6'd8; nk_m1 = 3'd7; total = 6'd60; old_word = win_q[7]; end
      default: begin nk = 6'd4; nk_m1 = 3'd3; total = 6'd44; old_word = win_q[3]; end
    endcase
  end

  assign prev_word = win_q[0];
  assign sbox_in   = (ph_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sbox u_sb0 (.a(sbox_in[31:24]), .y(sub_word[31:24]));
  aes_sbox u_sb1 (.a(sbox_in[23:16]), .y(sub_word[23:16]));
  aes_sbox u_sb2 (.a(sbox_in[15:8]),  .y(sub_word[15:8]));
  aes_sbox u_sb3 (.a(sbox_in[7:0]),   .y(sub_word[7:0]));

  always_comb begin
    if (ph_q == 3'd0)                          temp_word = sub_word ^ {rcon_q, 24'h0};
    else if (mode_q == 2'd2 && ph_q == 3'd4)   temp_word = sub_word;
    else                                       temp_word = prev_word;
  end

  assign new_word = (cnt_q < nk) ? key_q[255:224] : (old_word ^ temp_word);
  assign ksz_ok   = (ksz == 2'd0) || ((ksz == 2'd1) && ENABLE_192) || ((ksz == 2'd2) && ENABLE_256);
  assign accept   = rk_valid_q && rk_ready;
  assign fourth   = (cnt_q[1:0] == 2'd3);
  // The 4th word of a key goes straight to the output register; stall if it is still occupied.
  assign word_fire = (state_q == GEN) && !(fourth && rk_valid_q && !rk_ready);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    win_d      = win_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    rcon_d     = rcon_q;
    mode_d     = mode_q;
    rk_valid_d = rk_valid_q;
    wo0_d      = wo0_q;
    wo1_d      = wo1_q;
    wo2_d      = wo2_q;
    wo3_d      = wo3_q;
    rk_idx_d   = rk_idx_q;
    rk_last_d  = rk_last_q;
    ksz_err_d  = ksz_err_q;

    if (accept) rk_valid_d = 1'b0;

    if (word_fire) begin
      win_d[0] = new_word;
      for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
      key_d = {key_q[223:0], 32'h0};
      cnt_d = cnt_q + 6'd1;
      ph_d  = (ph_q == nk_m1) ? 3'd0 : ph_q + 3'd1;
      if (ph_q == 3'd0 && cnt_q >= nk)
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      if (fourth) begin
        wo0_d      = asm_q[0];
        wo1_d      = asm_q[1];
        wo2_d      = asm_q[2];
        wo3_d      = new_word;
        rk_valid_d = 1'b1;
        rk_idx_d   = cnt_q[5:2];
        rk_last_d  = (cnt_q == total - 6'd1);
        if (cnt_q == total - 6'd1) state_d = DRAIN;
      end else begin
        asm_d[cnt_q[1:0]] = new_word;
      end
    end

    if (state_q == DRAIN && accept && rk_last_q) state_d = IDLE;

    // A load aborts everything in flight and wins over a simultaneous handshake.
    if (kld) begin
      for (int k = 0; k < 8; k++) win_d[k] = 32'h0;
      for (int k = 0; k < 3; k++) asm_d[k] = 32'h0;
      cnt_d      = 6'd0;
      ph_d       = 3'd0;
      rcon_d     = 8'h01;
      rk_valid_d = 1'b0;
      wo0_d      = 32'h0;
      wo1_d      = 32'h0;
      wo2_d      = 32'h0;
      wo3_d      = 32'h0;
      rk_idx_d   = 4'd0;
      rk_last_d  = 1'b0;
      ksz_err_d  = !ksz_ok;
      key_d      = ksz_ok ? key : 256'h0;
      mode_d     = ksz_ok ? ksz : 2'd0;
      state_d    = ksz_ok ? GEN : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 256'h0;
      for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
      for (int k = 0; k < 3; k++) asm_q[k] <= 32'h0;
      cnt_q      <= 6'd0;
      ph_q       <= 3'd0;
      rcon_q     <= 8'h01;
      mode_q     <= 2'd0;
      rk_valid_q <= 1'b0;
      wo0_q      <= 32'h0;
      wo1_q      <= 32'h0;
      wo2_q      <= 32'h0;
      wo3_q      <= 32'h0;
      rk_idx_q   <= 4'd0;
      rk_last_q  <= 1'b0;
      ksz_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      win_q      <= win_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      rcon_q     <= rcon_d;
      mode_q     <= mode_d;
      rk_valid_q <= rk_valid_d;
      wo0_q      <= wo0_d;
      wo1_q      <= wo1_d;
      wo2_q      <= wo2_d;
      wo3_q      <= wo3_d;
      rk_idx_q   <= rk_idx_d;
      rk_last_q  <= rk_last_d;
      ksz_err_q  <= ksz_err_d;
    end
  end

  assign rk_valid = rk_valid_q;
  assign wo_0     = wo0_q;
  assign wo_1     = wo1_q;
  assign wo_2     = wo2_q;
  assign wo_3     = wo3_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;
  assign busy     = (state_q != IDLE);
  assign ksz_err  = ksz_err_q;
endmodule

// File: doc/aes_key_expand_gen.md
Name: aes_key_expand_gen

Overview:
- Parametrised successor to the fixed AES-128 key expander.
- Runtime-selectable AES-128/192/256 key schedule (FIPS-197 §5.2).
- Generates one 32-bit schedule word per cycle and assembles the words into 128-bit round keys, delivered over a valid/ready handshake to the cipher round datapath.
- Sits between key load logic and the aes_cipher/aes_inv_cipher round engines; replaces the combinational-per-round aes_key_expand_128 where multi-size support is needed.

Parameters:
- ENABLE_192, default 1: 1 = Nk=6 mode supported; 0 = ksz=1 is rejected.
- ENABLE_256, default 1: 1 = Nk=8 mode supported; 0 = ksz=2 is rejected.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- kld, input, 1: key load strobe; samples key and ksz.
- ksz, input, 2: key size; 0 = 128, 1 = 192, 2 = 256, 3 = illegal.
- key, input, 256: key; key[255:224] = w0, left-justified; unused low bits ignored (128: key[127:0]; 192: key[63:0]).
- rk_ready, input, 1: consumer accepts a round key.
- rk_valid, output, 1: wo_0..wo_3 hold a valid round key.
- wo_0, output, 32: round key word 4r.
- wo_1, output, 32: round key word 4r+1.
- wo_2, output, 32: round key word 4r+2.
- wo_3, output, 32: round key word 4r+3.
- rk_idx, output, 4: round number r of the presented key.
- rk_last, output, 1: presented key is round Nr (10/12/14).
- busy, output, 1: schedule in progress.
- ksz_err, output, 1: sticky; last kld carried an unsupported size.

Behaviour:
- Reset values: rk_valid=0, wo_0..wo_3=0, rk_idx=0, rk_last=0, busy=0, ksz_err=0. All internal state is cleared, including the 8x32 window, word counter and assembly buffer.
- Nk/Nr by mode: 4/10, 6/12, 8/14. Total words 4*(Nr+1) = 44/52/60.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE->GEN on kld with a supported ksz.
  - GEN->DRAIN when the final word has been generated.
  - DRAIN->IDLE when the rk_last key is accepted (rk_valid & rk_ready).
- kld sampled in any state, including mid-schedule: aborts the current schedule, flushes the output register and assembly buffer (rk_valid=0 the next cycle), then restarts with the new key. kld has priority over a simultaneous handshake.
- Illegal ksz (3, or a disabled mode) on kld: ksz_err=1, state goes to IDLE, no keys produced. ksz_err clears on the next legal kld.
- Word generation, one word i per cycle in GEN:
  - i < Nk: w[i] = key word.
  - else: w[i] = w[i-Nk] ^ temp.
    - temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk == 0.
    - temp = SubWord(w[i-1]) when Nk=8 and i mod 8 == 4.
    - otherwise temp = w[i-1].
- Rcon sequence 01,02,04,08,10,20,40,80,1b,36 in the MSB byte; a register doubles in GF(2^8) with 0x1b reduction. Four aes_sbox instances are used.
- Assembly: words shift into a 4-word buffer. On the 4th word the buffer transfers to wo_0..wo_3 (word 4r on wo_0) if the output register is empty or being accepted that cycle; otherwise generation stalls.
- Latency with rk_ready tied high: kld sampled at edge 0; word i is produced at edge i+1; round key r is rk_valid from edge 4r+4.
- Throughput: one key per 4 cycles.
- Backpressure: rk_valid, wo_*, rk_idx and rk_last hold stable until accepted. No word is lost or reordered. rk_ready has no effect while rk_valid=0.
- busy = (state != IDLE).
- Reset asserted mid-operation: immediate clear to reset values, no partial output.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> r0 == key, edge 4. r1 wo_0=a0fafe17, edge 8. r10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_idx=10, rk_last=1, edge 44. busy falls after acceptance.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> r1 = 62f8ead2 522c6b7b fe0c91f7 2402f5a5. r12 wo_3=01002202, rk_last=1, edge 52.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> r2 wo_0=9ba35411. r14 wo_3=706c631e, rk_idx=14, edge 60.
- Random rk_ready (~50%), AES-256 vector -> same 15 keys in order; outputs stable while rk_valid & !rk_ready.
- kld with AES-128 vector issued while a 256 schedule sits at r5 -> rk_valid=0 the next cycle; the 128 sequence then follows from r0 with no stale 256 keys. ksz=3 -> ksz_err=1, busy=0. ENABLE_192=0 with ksz=1 -> ksz_err=1.
- rst pulsed mid-GEN (asynchronous, between edges) -> outputs zero immediately; a subsequent kld yields a correct full schedule.
